// File: rtl/pmod_led_bank.sv
// pmod_led_bank: per-channel OFF/ON/BLINK/PWM LED driver behind a one-write-per-two-cycles config port.
// Optional macro LED_BANK_SYNC_EN: every valid write also phase-aligns all BLINK channels.
`timescale 1ns/1ps
module pmod_led_bank #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 24,
   parameter int PWM_WIDTH = 8
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              cfg_valid,
   output logic                                              cfg_ready,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
   input  logic [1:0]                                        cfg_mode,
   input  logic [CNT_WIDTH-1:0]                              cfg_param,
   output logic [CHANNELS-1:0]                               led
);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_PWM   = 2'b11;

`ifdef LED_BANK_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   logic                 cfg_ready_reg;
   logic [PWM_WIDTH-1:0] pwm_cnt_reg;
   logic                 wr_accept;
   logic                 wr_valid_chan;
   logic                 blink_sync;
   logic                 wr_led;

   assign cfg_ready     = cfg_ready_reg;
   assign wr_accept     = cfg_valid && cfg_ready_reg;
   // Out-of-range channel writes are still consumed, they just select nothing.
   assign wr_valid_chan = wr_accept && (32'(cfg_chan) < 32'(CHANNELS));
   assign blink_sync    = SYNC_EN && wr_valid_chan;

   // LED value the written channel takes on the accepting edge.
   always_comb begin
      wr_led = 1'b0;
      case (cfg_mode)
         MODE_ON, MODE_BLINK: wr_led = 1'b1;
         MODE_PWM:            wr_led = (pwm_cnt_reg < cfg_param[PWM_WIDTH-1:0]);
         default:             wr_led = 1'b0;
      endcase
   end

   // Ready drops for the single cycle after each accepted write; PWM counter free-runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_ready_reg <= 1'b0;
         pwm_cnt_reg   <= '0;
      end else begin
         cfg_ready_reg <= !wr_accept;
         pwm_cnt_reg   <= pwm_cnt_reg + PWM_WIDTH'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [1:0]           mode_reg;
         logic [CNT_WIDTH-1:0] param_reg;
         logic [CNT_WIDTH-1:0] cnt_reg;
         logic                 led_reg;
         logic                 wr_sel;
         logic                 duty_hit;

         assign wr_sel   = wr_valid_chan && (32'(cfg_chan) == 32'(gi));
         assign duty_hit = (pwm_cnt_reg < param_reg[PWM_WIDTH-1:0]);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mode_reg  <= MODE_OFF;
               param_reg <= '0;
               cnt_reg   <= '0;
               led_reg   <= 1'b0;
            end else if (wr_sel) begin
               mode_reg  <= cfg_mode;
               param_reg <= cfg_param;
               cnt_reg   <= '0;
               led_reg   <= wr_led;
            end else if (blink_sync && (mode_reg == MODE_BLINK)) begin
               cnt_reg <= '0;
               led_reg <= 1'b1;
            end else begin
               case (mode_reg)
                  MODE_ON: led_reg <= 1'b1;
                  MODE_BLINK: begin
                     // Counter never exceeds param, so it cannot overflow.
                     if (cnt_reg == param_reg) begin
                        cnt_reg <= '0;
                        led_reg <= !led_reg;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                     end
                  end
                  MODE_PWM: led_reg <= duty_hit;
                  default:  led_reg <= 1'b0;
               endcase
            end
         end

         assign led[gi] = led_reg;
      end
   endgenerate

endmodule

// File: tb/tb_pmod_led_bank.sv
// Directed, table-driven bench for pmod_led_bank (4-channel main instance, 3-channel instance for invalid-index writes).
`timescale 1ns/1ps
module tb_pmod_led_bank;

   localparam logic [1:0] OFF   = 2'b00;
   localparam logic [1:0] ON    = 2'b01;
   localparam logic [1:0] BLINK = 2'b10;
   localparam logic [1:0] PWM   = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_chan = '0;
   logic [1:0]  cfg_mode = '0;
   logic [23:0] cfg_param = '0;
   logic [3:0]  led;

   logic        v3 = 1'b0;
   logic        rdy3;
   logic [1:0]  c3 = '0;
   logic [1:0]  m3 = '0;
   logic [23:0] p3 = '0;
   logic [2:0]  led3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  ch;
      logic [1:0]  md;
      logic [23:0] pm;
      int          wait_cyc;
      logic [3:0]  exp_led;
   } vec_t;

   vec_t vecs [14];

   always #5 clk = ~clk;

   pmod_led_bank #(.CHANNELS(4), .CNT_WIDTH(24), .PWM_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_param(cfg_param), .led(led)
   );

   pmod_led_bank #(.CHANNELS(3), .CNT_WIDTH(24), .PWM_WIDTH(8)) dut3 (
      .clk(clk), .rst(rst), .cfg_valid(v3), .cfg_ready(rdy3),
      .cfg_chan(c3), .cfg_mode(m3), .cfg_param(p3), .led(led3)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic do_write(input logic [1:0] ch, input logic [1:0] md, input logic [23:0] pm);
      int n = 0;
      while (!cfg_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("write ready", {31'b0, cfg_ready}, 32'd1);
      cfg_valid = 1'b1;
      cfg_chan  = ch;
      cfg_mode  = md;
      cfg_param = pm;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("ready drop", {31'b0, cfg_ready}, 32'd0);
      $display("write ch=%0d mode=%0d param=%0d led=%b", ch, md, pm, led);
   endtask

   // BLINK param 7 model: high for 8 cycles, low for 8, measured from the write's return negedge.
   function automatic logic blink8(input longint origin);
      longint k;
      k = ($time - origin) / 10;
      return ((k / 8) % 2) == 0;
   endfunction

   initial begin
      longint o0, o1;
      int     highs;
      logic [3:0] exp4;

      vecs[0]  = '{2'd0, ON,    24'd0, 0, 4'b0001};
      vecs[1]  = '{2'd3, ON,    24'd0, 0, 4'b1001};
      vecs[2]  = '{2'd0, OFF,   24'd0, 0, 4'b1000};
      vecs[3]  = '{2'd1, BLINK, 24'd2, 0, 4'b1010};
      vecs[4]  = '{2'd1, BLINK, 24'd2, 2, 4'b1010};
      vecs[5]  = '{2'd1, BLINK, 24'd2, 3, 4'b1000};
      vecs[6]  = '{2'd1, BLINK, 24'd2, 6, 4'b1010};
      vecs[7]  = '{2'd1, OFF,   24'd0, 0, 4'b1000};
      vecs[8]  = '{2'd2, BLINK, 24'd0, 1, 4'b1000};
      vecs[9]  = '{2'd2, BLINK, 24'd0, 2, 4'b1100};
      vecs[10] = '{2'd2, OFF,   24'd0, 0, 4'b1000};
      vecs[11] = '{2'd3, OFF,   24'd0, 2, 4'b0000};
      vecs[12] = '{2'd0, PWM,   24'd0, 5, 4'b0000};
      vecs[13] = '{2'd0, OFF,   24'd0, 0, 4'b0000};

      // Reset state and release
      #2;
      check("reset led", {28'b0, led}, 32'd0);
      check("reset ready", {31'b0, cfg_ready}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("release ready", {31'b0, cfg_ready}, 32'd1);
      check("release led", {28'b0, led}, 32'd0);
      repeat (20) @(negedge clk);
      check("idle led", {28'b0, led}, 32'd0);
      check("idle ready", {31'b0, cfg_ready}, 32'd1);

      // Table-driven vectors
      for (int i = 0; i < 14; i++) begin
         do_write(vecs[i].ch, vecs[i].md, vecs[i].pm);
         repeat (vecs[i].wait_cyc) @(negedge clk);
         check($sformatf("vec%0d led", i), {28'b0, led}, {28'b0, vecs[i].exp_led});
      end

      // ch2 BLINK param 3: 4 high, 4 low, repeating
      do_write(2'd2, BLINK, 24'd3);
      for (int k = 0; k < 16; k++) begin
         exp4 = {1'b0, ((k / 4) % 2) == 0, 2'b00};
         check("blink3 led", {28'b0, led}, {28'b0, exp4});
         @(negedge clk);
      end
      do_write(2'd2, OFF, 24'd0);

      // PWM duty counts over one full period
      do_write(2'd0, PWM, 24'd64);
      highs = 0;
      for (int k = 0; k < 256; k++) begin
         if (led[0]) highs++;
         @(negedge clk);
      end
      check("pwm64 highs", 32'(highs), 32'd64);
      do_write(2'd0, PWM, 24'd0);
      highs = 0;
      for (int k = 0; k < 256; k++) begin
         if (led[0]) highs++;
         @(negedge clk);
      end
      check("pwm0 highs", 32'(highs), 32'd0);
      do_write(2'd0, PWM, 24'd255);
      highs = 0;
      for (int k = 0; k < 256; k++) begin
         if (led[0]) highs++;
         @(negedge clk);
      end
      check("pwm255 highs", 32'(highs), 32'd255);
      do_write(2'd0, OFF, 24'd0);

      // cfg_valid held high with alternating channels: only ch0/ch2 land
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         cfg_valid = 1'b1;
         cfg_chan  = 2'(i);
         cfg_mode  = ON;
         cfg_param = '0;
         check("held ready", {31'b0, cfg_ready}, {31'b0, (i % 2) == 0});
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      check("held led", {28'b0, led}, 32'b0101);
      $display("held-valid burst led=%b", led);
      do_write(2'd0, OFF, 24'd0);
      do_write(2'd2, OFF, 24'd0);

      // Out-of-range channel on the 3-channel instance
      v3 = 1'b1; c3 = 2'd0; m3 = ON; p3 = '0;
      @(negedge clk);
      v3 = 1'b0;
      check("c3 led after ch0", {29'b0, led3}, 32'b001);
      check("c3 ready drop", {31'b0, rdy3}, 32'd0);
      @(negedge clk);
      check("c3 ready back", {31'b0, rdy3}, 32'd1);
      v3 = 1'b1; c3 = 2'd3; m3 = ON;
      @(negedge clk);
      v3 = 1'b0;
      check("c3 bad ready drop", {31'b0, rdy3}, 32'd0);
      check("c3 bad led", {29'b0, led3}, 32'b001);
      $display("invalid-channel write led3=%b", led3);
      @(negedge clk);
      check("c3 bad ready back", {31'b0, rdy3}, 32'd1);
      check("c3 bad led later", {29'b0, led3}, 32'b001);

      // Phase relation of two BLINK channels written 3 cycles apart
      do_write(2'd0, BLINK, 24'd7);
      o0 = $time;
      repeat (2) @(negedge clk);
      do_write(2'd1, BLINK, 24'd7);
      o1 = $time;
`ifdef LED_BANK_SYNC_EN
      o0 = o1;
`endif
      do_write(2'd3, ON, 24'd0);
`ifdef LED_BANK_SYNC_EN
      o0 = $time;
      o1 = $time;
`endif
      for (int k = 0; k < 32; k++) begin
         exp4 = {1'b1, 1'b0, blink8(o1), blink8(o0)};
         check("blink phase", {28'b0, led}, {28'b0, exp4});
         @(negedge clk);
      end

      // Asynchronous reset mid-blink with a write pending
      do_write(2'd1, BLINK, 24'd10);
      do_write(2'd1, BLINK, 24'd10);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_mode = ON; cfg_param = '0;
      #1;
      check("async rst led", {28'b0, led}, 32'd0);
      check("async rst ready", {31'b0, cfg_ready}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      cfg_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post rst ready", {31'b0, cfg_ready}, 32'd1);
      check("post rst led", {28'b0, led}, 32'd0);
      repeat (20) @(negedge clk);
      check("post rst ch1 off", {28'b0, led}, 32'd0);
      $display("reset pulse done led=%b", led);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
